// File: rtl/aes_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : aes_job_scheduler
// Description : Shares one AES core between two requesters. Jobs are only
//               issued once the key schedule is valid. Port selection is
//               round-robin. The scheduler drives the core's start pulse and
//               returns each result tagged with the ID of its requester.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : TIMEOUT_CYCLES - longest WAIT time before a job is aborted
//               (used only when AES_SCHED_TIMEOUT_EN is defined)
// Optional    : `define AES_SCHED_TIMEOUT_EN adds a WAIT watchdog counter
// Ports       :
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_dec [1:0]    per-port request and opcode (1 = decrypt)
//   req_data0/req_data1        per-port 128-bit input blocks
//   req_ready [1:0]            per-port accept, one-hot or zero
//   resp_valid/id/data/err     tagged result; held until resp_ready
//   aes_pt_valid/aes_pt_encr   encrypt start pulse and block to core
//   aes_ct_valid/aes_ct_decr   decrypt start pulse and block to core
//   aes_ct_rdy/aes_ct_encr     encrypt done and result from core
//   aes_pt_rdy/aes_pt_decr     decrypt done and result from core
//   aes_key_exp_status         round keys valid
//   aes_error                  core error flag
//   busy, jobs_done            activity flag, saturating response count
// ============================================================================
module aes_job_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    input  logic [1:0]   req_dec,
    input  logic [127:0] req_data0,
    input  logic [127:0] req_data1,
    output logic [1:0]   req_ready,
    output logic         resp_valid,
    output logic         resp_id,
    output logic [127:0] resp_data,
    output logic         resp_err,
    input  logic         resp_ready,
    output logic         aes_pt_valid,
    output logic [127:0] aes_pt_encr,
    output logic         aes_ct_valid,
    output logic [127:0] aes_ct_decr,
    input  logic         aes_ct_rdy,
    input  logic [127:0] aes_ct_encr,
    input  logic         aes_pt_rdy,
    input  logic [127:0] aes_pt_decr,
    input  logic         aes_key_exp_status,
    input  logic         aes_error,
    output logic         busy,
    output logic [15:0]  jobs_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic           rr_q, rr_d;
    logic           dec_q, dec_d;
    logic           id_q, id_d;
    logic           guard_q, guard_d;
    logic [127:0]   pt_q, pt_d;
    logic [127:0]   ct_q, ct_d;
    logic [127:0]   rdata_q, rdata_d;
    logic           rerr_q, rerr_d;
    logic [15:0]    cnt_q, cnt_d;

    logic           w_can_grant;
    logic           w_gnt;
    logic [127:0]   w_gnt_data;
    logic           w_done;
    logic [127:0]   w_result;
    logic           w_timeout;

    // Port rr has priority; the other port wins only if rr is not requesting.
    assign w_can_grant = (|req_valid) & aes_key_exp_status & ~aes_error;
    assign w_gnt       = req_valid[rr_q] ? rr_q : ~rr_q;
    assign w_gnt_data  = w_gnt ? req_data1 : req_data0;

    // Only the done line that matches the job's opcode is observed.
    assign w_done   = dec_q ? aes_pt_rdy  : aes_ct_rdy;
    assign w_result = dec_q ? aes_pt_decr : aes_ct_encr;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    // wcnt_q holds the number of WAIT cycles already elapsed, so the job is
    // aborted on the TIMEOUT_CYCLES-th WAIT cycle.
    assign w_timeout = (state_q == S_WAIT) && (wcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wcnt_d = wcnt_q;
        if (state_q == S_ISSUE) begin
            wcnt_d = '0;
        end else if (state_q == S_WAIT) begin
            wcnt_d = wcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    logic unused_timeout;

    assign w_timeout      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        dec_d        = dec_q;
        id_d         = id_q;
        guard_d      = guard_q;
        pt_d         = pt_q;
        ct_d         = ct_q;
        rdata_d      = rdata_q;
        rerr_d       = rerr_q;
        cnt_d        = cnt_q;
        req_ready    = 2'b00;
        aes_pt_valid = 1'b0;
        aes_ct_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_can_grant) begin
                    req_ready[w_gnt] = 1'b1;
                    dec_d            = req_dec[w_gnt];
                    id_d             = w_gnt;
                    if (req_dec[w_gnt]) begin
                        ct_d = w_gnt_data;
                    end else begin
                        pt_d = w_gnt_data;
                    end
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                aes_pt_valid = ~dec_q;
                aes_ct_valid = dec_q;
                guard_d      = 1'b1;
                state_d      = S_WAIT;
            end

            S_WAIT: begin
                guard_d = 1'b0;
                // The first WAIT cycle is skipped so that a done flag left over
                // from the core's previous operation is never mistaken for
                // this job's completion.
                if (!guard_q && aes_error) begin
                    rerr_d  = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else if (!guard_q && w_done) begin
                    rerr_d  = 1'b0;
                    rdata_d = w_result;
                    state_d = S_RESP;
                end else if (w_timeout) begin
                    rerr_d  = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    rr_d = ~id_q;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            dec_q   <= 1'b0;
            id_q    <= 1'b0;
            guard_q <= 1'b0;
            pt_q    <= '0;
            ct_q    <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            dec_q   <= dec_d;
            id_q    <= id_d;
            guard_q <= guard_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign resp_valid  = (state_q == S_RESP);
    assign resp_id     = id_q;
    assign resp_data   = rdata_q;
    assign resp_err    = rerr_q;
    assign aes_pt_encr = pt_q;
    assign aes_ct_decr = ct_q;
    assign busy        = (state_q != S_IDLE);
    assign jobs_done   = cnt_q;

endmodule
`default_nettype wire
